// File: rtl/sample_capture_fifo_if.sv
// Bus bundle for sample_capture_fifo: capture side, read side and status.
// The master is whoever drives capture/read requests (sensor glue plus CPU);
// the slave is the FIFO itself.
interface sample_capture_fifo_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // capture side
  logic              en;
  logic              sample_ce;
  logic [DATA_W-1:0] sample_data;
  // read side
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  // status / control
  logic [LW-1:0]     level;
  logic [LW-1:0]     watermark;
  logic              irq;
  logic              overflow;
  logic              clr_ovf;
  logic [31:0]       sample_cnt;

  modport master (
    output en, sample_ce, sample_data, rd_en, watermark, clr_ovf,
    input  rd_data, rd_valid, level, irq, overflow, sample_cnt
  );

  modport slave (
    input  en, sample_ce, sample_data, rd_en, watermark, clr_ovf,
    output rd_data, rd_valid, level, irq, overflow, sample_cnt
  );
endinterface

// File: rtl/sample_capture_fifo.sv
// Sample capture FIFO: pushes one word per enabled sample_ce pulse into a
// circular buffer, drains through a 1-cycle-latency read strobe, and reports
// occupancy, a watermark interrupt and a sticky overflow flag.
// Full/empty are decided by the occupancy counter, never by pointer equality.
module sample_capture_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  sample_capture_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  // storage (no reset so it can map onto block RAM)
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_irq;
  logic              r_overflow;
  logic [31:0]       r_sample_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic [LW-1:0]     w_level_next;
  logic              w_irq_next;

  // request decode: a push into a full FIFO still lands when a pop frees a slot
  always_comb begin
    w_push = bus.en & bus.sample_ce;
    w_pop  = bus.rd_en & (r_level != '0);
    w_full = (r_level == LVL_FULL);
    w_wr   = w_push & (~w_full | w_pop);
    w_drop = w_push & w_full & ~w_pop;
  end

  // next occupancy and the interrupt condition evaluated on it
  always_comb begin
    w_level_next = r_level;
    unique case ({w_wr, w_pop})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
    // level never exceeds DEPTH, so a watermark above DEPTH can never fire
    w_irq_next = (bus.watermark != '0) && (w_level_next >= bus.watermark);
  end

  // memory write port
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.sample_data;
    end
  end

  // pointers, occupancy and capture counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_sample_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_sample_cnt <= r_sample_cnt + 32'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_next;
    end
  end

  // registered read port; rd_data holds its last value when nothing pops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // status flags: irq tracks next level, overflow is sticky with set over clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_irq <= w_irq_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.level      = r_level;
  assign bus.irq        = r_irq;
  assign bus.overflow   = r_overflow;
  assign bus.sample_cnt = r_sample_cnt;

endmodule
